leading_run_counter_pipe: RTL
=============================

Name: leading_run_counter_pipe

Overview:
Pipelined, parametrised leading-run counter for the decode path. It counts how many consecutive bits, starting at the MSB, equal a selected leading bit. The leading bit is either taken from the word's MSB or supplied externally. It replaces the fixed 2- and 4-bit combinational counters with a WIDTH-generic tree built from CHUNK-bit leaf counters. Registered merge levels, a valid/ready handshake and a sideband tag make it suitable for posit regime decoding at full clock rate.

Parameters:
WIDTH, 32, input word width; power of 2, >= CHUNK.
CHUNK, 4, leaf counter width; power of 2, >= 2, divides WIDTH.
TAG_W, 4, sideband tag width carried alongside each beat; >= 1.
Derived: NLEAF = WIDTH/CHUNK; LEVELS = log2(NLEAF); LAT = LEVELS+1; CW = $clog2(WIDTH+1).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
in_data  in  WIDTH  word to scan from MSB.
in_lead_sel  in  1  1: leading bit = in_data[WIDTH-1]; 0: leading bit = in_lead.
in_lead  in  1  external leading bit, used when in_lead_sel=0.
in_tag  in  TAG_W  sideband, returned unchanged with the result.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_count  out  CW  run length, 0..WIDTH.
out_all  out  1  1 when out_count == WIDTH.
out_lead  out  1  leading bit actually used.
out_tag  out  TAG_W  tag of this beat.

Behaviour:
- One clock; reset is synchronous and active-high. While rst=1 at an edge, every pipeline valid bit clears and all data/count/tag registers load 0.
- After reset: out_valid=0, out_count=0, out_all=0, out_lead=0, out_tag=0. in_ready is combinational and reads 1 while the output is empty.
- Global enable: adv = !out_valid || out_ready. in_ready = adv. The whole pipeline shifts only when adv=1. Bubbles are not squeezed out.
- Accept: a beat is taken when in_valid && in_ready. The result appears on out_* exactly LAT cycles after acceptance when unstalled. Beats leave in order with no loss or duplication.
- Stage 0, leaf counting:
  - Resolve lead = in_lead_sel ? in_data[WIDTH-1] : in_lead.
  - Leaf i covers bits [WIDTH-1-i*CHUNK -: CHUNK].
  - Each leaf counts leading bits equal to lead, range 0..CHUNK.
  - The registered stage holds all leaf counts, lead, tag and valid.
- Merge levels k=1..LEVELS, each registered:
  - Each pair (hi, lo) covers half-spans of h = CHUNK*2^(k-1) bits.
  - Merged count = (hi == h) ? h + lo : hi.
  - Count width at level k is $clog2(2h+1). Zero-extend on combine; no truncation.
- Final level yields a single count (CW bits); out_all = (count == WIDTH).
- Holding under stall: while out_valid && !out_ready, all registers hold and out_* stay stable.
- Input while stalled: in_valid with in_ready=0 is ignored. Upstream holds data.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 the cycle after reset, and no pre-reset beat ever emerges.
- in_valid=0 while adv=1: a bubble enters the pipe; its valid=0 and its payload is don't-care.
- Leaf counting and merges are pure functions; no state beyond the pipeline registers.

Test Plan:
WIDTH=32, CHUNK=4, TAG_W=4, LAT=4.
- in_data=0xF000_0000, lead_sel=0, lead=1, tag=3, out_ready=1 -> 4 cycles after accept: out_count=4, out_all=0, out_lead=1, out_tag=3.
- lead_sel=1: in_data=0x0000_0000 -> count=32, all=1, lead=0; next beat 0xFFFF_FFFF -> count=32, all=1, lead=1.
- lead_sel=1, 0x07FF_FFFF -> count=5 (crosses leaf boundary); 0x8000_0000 -> count=1; lead_sel=0, lead=0, 0x8000_0000 -> count=0.
- 8 back-to-back beats, tags 0..7, out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, out_* stable, then tags 0..7 in order with correct counts.
- 3 beats in flight, rst=1 for 1 cycle -> out_valid=0 next cycle and thereafter until new input. First post-reset beat returns after exactly 4 cycles.
- in_valid toggled 1,0,1,0 with out_ready=1 -> results on alternate cycles, 4 cycles after each accept, bubbles never raise out_valid.

Source files
------------

// File: rtl/leading_run_counter_pipe.sv
// leading_run_counter_pipe: counts MSB-first run of bits equal to a selected lead bit,
// using CHUNK-bit leaf counters merged by a registered binary tree under a single valid/ready enable.
module leading_run_counter_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int TAG_W = 4,
    localparam int NLEAF = WIDTH / CHUNK,
    localparam int LEVELS = $clog2(NLEAF),
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lead_sel,
    input  logic             in_lead,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_all,
    output logic             out_lead,
    output logic [TAG_W-1:0] out_tag
);
    logic adv;
    logic lead_in;
    // Heap-ordered tree: node 1 is the root, children of n are 2n (MSB side) and 2n+1.
    logic [CW-1:0] node_d [1:2*NLEAF-1];
    logic [CW-1:0] node_q [1:2*NLEAF-1];
    logic vld_q [0:LEVELS];
    logic lead_q [0:LEVELS];
    logic [TAG_W-1:0] tag_q [0:LEVELS];

    function automatic logic [CW-1:0] leaf_count(input logic [CHUNK-1:0] b, input logic l);
        logic run;
        logic [CW-1:0] n;
        run = 1'b1;
        n = '0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            run = run && (b[j] == l);
            n = n + CW'(run);
        end
        return n;
    endfunction

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign lead_in = in_lead_sel ? in_data[WIDTH-1] : in_lead;

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        assign node_d[NLEAF+i] = leaf_count(in_data[WIDTH-1-i*CHUNK -: CHUNK], lead_in);
    end

    for (genvar n = 1; n < NLEAF; n++) begin : g_merge
        localparam int H = (WIDTH >> ($clog2(n + 1) - 1)) / 2;
        assign node_d[n] = (node_q[2*n] == CW'(H)) ? CW'(H) + node_q[2*n+1] : node_q[2*n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 1; n < 2 * NLEAF; n++) node_q[n] <= '0;
            for (int s = 0; s <= LEVELS; s++) begin
                vld_q[s] <= 1'b0;
                lead_q[s] <= 1'b0;
                tag_q[s] <= '0;
            end
        end else if (adv) begin
            node_q <= node_d;
            vld_q[0] <= in_valid;
            lead_q[0] <= lead_in;
            tag_q[0] <= in_tag;
            for (int s = 1; s <= LEVELS; s++) begin
                vld_q[s] <= vld_q[s-1];
                lead_q[s] <= lead_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LEVELS];
    assign out_lead = lead_q[LEVELS];
    assign out_tag = tag_q[LEVELS];
    assign out_count = node_q[1];
    assign out_all = node_q[1] == CW'(WIDTH);
endmodule
